// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// fills the IF/ID register read directly by decode. Handles decode stalls via a
// one-entry hold buffer and branch redirects by flushing and dropping the
// in-flight response.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add the sticky
// fetch_misalign output and halt fetch on a misaligned redirect target.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_ID,
    output logic [31:0] pc_ID,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fetch_misalign,
`endif
    output logic        valid_ID
);

    typedef enum logic [2:0] {
        StReq,
        StWait,
        StHold,
        StDrop
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        StHalt
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_id_q, valid_id_d;
    logic [31:0] hold_q, hold_d;
    logic        misalign_q, misalign_d;

    logic        can_load;
    logic        req_hs;
    logic        redirect_take;
    logic [31:0] redirect_aligned;

    // Request outputs; suppressed during the reset cycle itself.
    always_comb begin
        imem_req_valid = (state_q == StReq) && !reset;
        imem_addr      = pc_q;
    end

    assign inst_ID  = inst_id_q;
    assign pc_ID    = pc_id_q;
    assign valid_ID = valid_id_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_misalign = misalign_q;
`endif

    assign can_load         = !valid_id_q || !stall_ID;
    assign req_hs           = imem_req_valid && imem_req_ready;
    assign redirect_aligned = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
    // Once halted, redirects no longer restart fetch.
    assign redirect_take = redirect_valid && (state_q != StHalt);
`else
    assign redirect_take = redirect_valid;
`endif

    // Next-state: FSM, PC, IF/ID register and hold buffer; redirect overrides all.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_id_d  = inst_id_q;
        pc_id_d    = pc_id_q;
        valid_id_d = valid_id_q;
        hold_d     = hold_q;
        misalign_d = misalign_q;

        // Decode consumed the current entry and nothing new arrives: go empty.
        if (valid_id_q && !stall_ID) begin
            valid_id_d = 1'b0;
            inst_id_d  = NOP_INST;
        end

        unique case (state_q)
            StReq: begin
                if (req_hs) state_d = StWait;
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (can_load) begin
                        inst_id_d  = imem_rsp_data;
                        pc_id_d    = pc_q;
                        valid_id_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = StReq;
                    end else begin
                        hold_d  = imem_rsp_data;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (can_load) begin
                    inst_id_d  = hold_q;
                    pc_id_d    = pc_q;
                    valid_id_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = StReq;
                end
            end
            StDrop: begin
                if (imem_rsp_valid) state_d = StReq;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: state_d = StReq;
        endcase

        if (redirect_take) begin
            pc_d       = redirect_aligned;
            valid_id_d = 1'b0;
            inst_id_d  = NOP_INST;
            case (state_q)
                StReq:   state_d = req_hs ? StDrop : StReq;
                StWait:  state_d = imem_rsp_valid ? StReq : StDrop;
                StDrop:  state_d = StDrop;
                default: state_d = StReq;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = StHalt;
            end
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            inst_id_q  <= NOP_INST;
            pc_id_q    <= 32'h0;
            valid_id_q <= 1'b0;
            hold_q     <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_id_q  <= inst_id_d;
            pc_id_q    <= pc_id_d;
            valid_id_q <= valid_id_d;
            hold_q     <= hold_d;
            misalign_q <= misalign_d;
        end
    end

`ifndef SYNTHESIS
    // A response with no request outstanding is a memory protocol violation.
    property p_no_stray_rsp;
        @(posedge clk) disable iff (reset)
            !(imem_rsp_valid && (state_q == StReq || state_q == StHold));
    endproperty
    a_no_stray_rsp: assert property (p_no_stray_rsp);
`endif

endmodule
